fp_mul_pipe: RTL and testbench

//   Parametrised, pipelined IEEE-754 floating-point multiplier with valid/ready handshakes on both sides.

---
 rtl/fp_mul_pipe.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined IEEE-754 multiplier with valid/ready handshakes.
//   Stage 1 unpacks the operands, classifies them and forms the full mantissa product.
//   Stage 2 normalises by at most one place and rounds using guard + sticky.
//   Stage 3 resolves specials, overflow by rounding mode and underflow, then packs.
// Subnormal inputs are flushed to zero and no subnormal result is ever produced.
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_W+FRAC_W:0]       fp_X,
  input  logic [EXP_W+FRAC_W:0]       fp_Y,
  input  logic [2:0]                  r_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_W+FRAC_W:0]       fp_Z,
  output logic                        ovrf,
  output logic                        udrf,
  output logic                        zer,
  output logic                        inf,
  output logic                        nan
);

  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int MW   = FRAC_W + 1;          // mantissa width including hidden one
  localparam int PW   = 2 * MW;              // full product width
  localparam int EW   = EXP_W + 2;           // exponent working width (sign + headroom)
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic [EW-1:0]     BIAS_EW   = EW'(BIAS);
  localparam logic [EW-1:0]     EXP_LIMIT = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]  EXP_ONES  = '1;
  localparam logic [EXP_W-1:0]  EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [FRAC_W-1:0] FRAC_ONES = '1;
  localparam logic [FRAC_W-1:0] QNAN_FRAC = {1'b1, {(FRAC_W-1){1'b0}}};

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // ---------------------------------------------------------------------------
  // Handshake: every stage moves together, only when the output slot frees up.
  // ---------------------------------------------------------------------------
  logic rdy_en_reg;
  logic advance;
  logic accept;
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s3_valid_reg;

  assign advance   = !s3_valid_reg || out_ready;
  assign in_ready  = rdy_en_reg && advance;
  assign accept    = in_valid && in_ready;
  assign out_valid = s3_valid_reg;

  // in_ready stays low while in reset and for the first cycle after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_reg <= 1'b0;
    else        rdy_en_reg <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Operand unpack and classification, identical for both operands.
  // ---------------------------------------------------------------------------
  logic [W-1:0]      op_word [2];
  logic              op_sign [2];
  logic [EXP_W-1:0]  op_exp  [2];
  logic [FRAC_W-1:0] op_frac [2];
  logic              op_nan  [2];
  logic              op_inf  [2];
  logic              op_zero [2];

  assign op_word[0] = fp_X;
  assign op_word[1] = fp_Y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_sign[gi] = op_word[gi][W-1];
      assign op_exp[gi]  = op_word[gi][W-2 -: EXP_W];
      assign op_frac[gi] = op_word[gi][FRAC_W-1:0];
      assign op_nan[gi]  = (op_exp[gi] == EXP_ONES) && (op_frac[gi] != '0);
      assign op_inf[gi]  = (op_exp[gi] == EXP_ONES) && (op_frac[gi] == '0);
      // exp==0 covers both true zero and flushed subnormals
      assign op_zero[gi] = (op_exp[gi] == '0);
    end
  endgenerate

  // Class is resolved here with full priority so later stages carry one-hot flags.
  logic          cls_nan_c;
  logic          cls_inf_c;
  logic          cls_zero_c;
  logic          sign_c;
  logic [EW-1:0] exp_sum_c;
  logic [PW-1:0] prod_c;
  logic [2:0]    rm_c;

  assign cls_nan_c  = op_nan[0] || op_nan[1] ||
                      (op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0]);
  assign cls_inf_c  = !cls_nan_c && (op_inf[0] || op_inf[1]);
  assign cls_zero_c = !cls_nan_c && !cls_inf_c && (op_zero[0] || op_zero[1]);
  assign sign_c     = op_sign[0] ^ op_sign[1];
  assign exp_sum_c  = {2'b00, op_exp[0]} + {2'b00, op_exp[1]} - BIAS_EW;
  assign prod_c     = {{MW{1'b0}}, 1'b1, op_frac[0]} * {{MW{1'b0}}, 1'b1, op_frac[1]};
  // Reserved rounding-mode encodings behave as round-to-nearest-even
  assign rm_c       = (r_mode > RM_RMM) ? RM_RNE : r_mode;

  logic          s1_sign_reg;
  logic          s1_nan_reg;
  logic          s1_inf_reg;
  logic          s1_zero_reg;
  logic [EW-1:0] s1_exp_reg;
  logic [PW-1:0] s1_prod_reg;
  logic [2:0]    s1_rm_reg;

  // Stage 1 register: capture classified operands and the raw mantissa product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_nan_reg   <= 1'b0;
      s1_inf_reg   <= 1'b0;
      s1_zero_reg  <= 1'b0;
      s1_exp_reg   <= '0;
      s1_prod_reg  <= '0;
      s1_rm_reg    <= RM_RNE;
    end else if (advance) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_sign_reg <= sign_c;
        s1_nan_reg  <= cls_nan_c;
        s1_inf_reg  <= cls_inf_c;
        s1_zero_reg <= cls_zero_c;
        s1_exp_reg  <= exp_sum_c;
        s1_prod_reg <= prod_c;
        s1_rm_reg   <= rm_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 logic: normalise (product of two [1,2) values lies in [1,4)) and round.
  // ---------------------------------------------------------------------------
  logic              norm_c;
  logic [PW-1:0]     prod_n_c;
  logic [FRAC_W-1:0] frac_keep_c;
  logic              guard_c;
  logic              sticky_c;
  logic              round_up_c;
  logic [FRAC_W:0]   frac_sum_c;
  logic              rcarry_c;
  logic [EW-1:0]     exp_norm_c;

  assign norm_c      = s1_prod_reg[PW-1];
  assign prod_n_c    = norm_c ? s1_prod_reg : {s1_prod_reg[PW-2:0], 1'b0};
  // After alignment the hidden one sits at PW-1; the kept fraction follows it
  assign frac_keep_c = prod_n_c[PW-2 -: FRAC_W];
  assign guard_c     = prod_n_c[FRAC_W];
  assign sticky_c    = |prod_n_c[FRAC_W-1:0];

  // Rounding increment decision per mode from guard, sticky and result sign
  always_comb begin
    round_up_c = 1'b0;
    case (s1_rm_reg)
      RM_RTZ:  round_up_c = 1'b0;
      RM_RDN:  round_up_c = s1_sign_reg && (guard_c || sticky_c);
      RM_RUP:  round_up_c = !s1_sign_reg && (guard_c || sticky_c);
      RM_RMM:  round_up_c = guard_c;
      default: round_up_c = guard_c && (sticky_c || frac_keep_c[0]);
    endcase
  end

  // A carry out of the fraction leaves it all-zero, i.e. mantissa 1.0 at exp+1
  assign frac_sum_c = {1'b0, frac_keep_c} + {{FRAC_W{1'b0}}, round_up_c};
  assign rcarry_c   = frac_sum_c[FRAC_W];
  assign exp_norm_c = s1_exp_reg + EW'(norm_c) + EW'(rcarry_c);

  logic              s2_sign_reg;
  logic              s2_nan_reg;
  logic              s2_inf_reg;
  logic              s2_zero_reg;
  logic [EW-1:0]     s2_exp_reg;
  logic [FRAC_W-1:0] s2_frac_reg;
  logic [2:0]        s2_rm_reg;

  // Stage 2 register: rounded fraction and final unclamped exponent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_nan_reg   <= 1'b0;
      s2_inf_reg   <= 1'b0;
      s2_zero_reg  <= 1'b0;
      s2_exp_reg   <= '0;
      s2_frac_reg  <= '0;
      s2_rm_reg    <= RM_RNE;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sign_reg <= s1_sign_reg;
        s2_nan_reg  <= s1_nan_reg;
        s2_inf_reg  <= s1_inf_reg;
        s2_zero_reg <= s1_zero_reg;
        s2_exp_reg  <= exp_norm_c;
        s2_frac_reg <= frac_sum_c[FRAC_W-1:0];
        s2_rm_reg   <= s1_rm_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 logic: exceptions, overflow/underflow and packing.
  // ---------------------------------------------------------------------------
  logic         exp_neg_c;
  logic         exp_ovf_c;
  logic         exp_udf_c;
  logic         ovf_to_inf_c;
  logic [W-1:0] z_c;
  logic         ovrf_c;
  logic         udrf_c;
  logic         zer_c;
  logic         inf_c;
  logic         nan_c;

  assign exp_neg_c = s2_exp_reg[EW-1];
  assign exp_ovf_c = !exp_neg_c && (s2_exp_reg >= EXP_LIMIT);
  assign exp_udf_c = exp_neg_c || (s2_exp_reg == '0);

  // Overflow saturates to infinity only when the rounding direction points away from zero
  always_comb begin
    ovf_to_inf_c = 1'b1;
    case (s2_rm_reg)
      RM_RTZ:  ovf_to_inf_c = 1'b0;
      RM_RDN:  ovf_to_inf_c = s2_sign_reg;
      RM_RUP:  ovf_to_inf_c = !s2_sign_reg;
      default: ovf_to_inf_c = 1'b1;
    endcase
  end

  // Result selection in priority order: NaN, infinity, zero, then the normal path
  always_comb begin
    z_c    = '0;
    ovrf_c = 1'b0;
    udrf_c = 1'b0;
    zer_c  = 1'b0;
    inf_c  = 1'b0;
    nan_c  = 1'b0;
    if (s2_nan_reg) begin
      z_c   = {1'b0, EXP_ONES, QNAN_FRAC};
      nan_c = 1'b1;
    end else if (s2_inf_reg) begin
      z_c   = {s2_sign_reg, EXP_ONES, {FRAC_W{1'b0}}};
      inf_c = 1'b1;
    end else if (s2_zero_reg) begin
      z_c   = {s2_sign_reg, {(W-1){1'b0}}};
      zer_c = 1'b1;
    end else if (exp_ovf_c) begin
      ovrf_c = 1'b1;
      if (ovf_to_inf_c) begin
        z_c   = {s2_sign_reg, EXP_ONES, {FRAC_W{1'b0}}};
        inf_c = 1'b1;
      end else begin
        z_c = {s2_sign_reg, EXP_MAXF, FRAC_ONES};
      end
    end else if (exp_udf_c) begin
      z_c    = {s2_sign_reg, {(W-1){1'b0}}};
      udrf_c = 1'b1;
      zer_c  = 1'b1;
    end else begin
      z_c = {s2_sign_reg, s2_exp_reg[EXP_W-1:0], s2_frac_reg};
    end
  end

  logic [W-1:0] z_reg;
  logic         ovrf_reg;
  logic         udrf_reg;
  logic         zer_reg;
  logic         inf_reg;
  logic         nan_reg;

  // Stage 3 register: result and flags; frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_reg <= 1'b0;
      z_reg        <= '0;
      ovrf_reg     <= 1'b0;
      udrf_reg     <= 1'b0;
      zer_reg      <= 1'b0;
      inf_reg      <= 1'b0;
      nan_reg      <= 1'b0;
    end else if (advance) begin
      s3_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        z_reg    <= z_c;
        ovrf_reg <= ovrf_c;
        udrf_reg <= udrf_c;
        zer_reg  <= zer_c;
        inf_reg  <= inf_c;
        nan_reg  <= nan_c;
      end
    end
  end

  assign fp_Z = z_reg;
  assign ovrf = ovrf_reg;
  assign udrf = udrf_reg;
  assign zer  = zer_reg;
  assign inf  = inf_reg;
  assign nan  = nan_reg;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Testbench for fp_mul_pipe (single precision): directed table, latency,
// backpressure and mid-stream reset sequences, then randomized traffic
// checked against an arithmetic reference model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp_X = '0;
  logic [31:0] fp_Y = '0;
  logic [2:0]  r_mode = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf, udrf, zer, inf, nan;

  logic ready_force = 1'b1;
  logic ready_rand  = 1'b0;
  logic rnd_ready   = 1'b1;
  assign out_ready = ready_rand ? rnd_ready : ready_force;

  fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid),
    .out_ready(out_ready), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf),
    .zer(zer), .inf(inf), .nan(nan)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int delivered = 0;
  logic [36:0] exp_q [$];   // {fp_Z, ovrf, udrf, zer, inf, nan}

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  rm;
    logic [31:0] z;
    logic [4:0]  f;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded part against half an ulp.
  function automatic logic [36:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    logic s;
    int ex, ey, e, k, mode;
    longint unsigned ma, mb, m, q, rem, half;
    logic up, to_inf;
    s = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mode = (rm > 3'd4) ? 0 : int'(rm);
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
        (ex == 255 && ey == 0) || (ey == 255 && ex == 0))
      return {32'h7FC00000, 5'b00001};
    if (ex == 255 || ey == 255) return {s, 8'hFF, 23'd0, 5'b00010};
    if (ex == 0 || ey == 0) return {s, 31'd0, 5'b00100};
    ma = {40'd0, 1'b1, x[22:0]};
    mb = {40'd0, 1'b1, y[22:0]};
    m = ma * mb;
    k = (m >= (64'd1 << 47)) ? 24 : 23;
    q = m >> k;
    rem = m & ((64'd1 << k) - 64'd1);
    half = 64'd1 << (k - 1);
    case (mode)
      0: up = (rem > half) || (rem == half && q[0]);
      1: up = 1'b0;
      2: up = s && (rem != 0);
      3: up = !s && (rem != 0);
      default: up = (rem >= half);
    endcase
    q = q + {63'd0, up};
    e = ex + ey - 127 + (k - 23);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) begin
      to_inf = (mode == 0) || (mode == 4) || (mode == 2 && s) || (mode == 3 && !s);
      return to_inf ? {s, 8'hFF, 23'd0, 5'b10010} : {s, 8'hFE, 23'h7FFFFF, 5'b10000};
    end
    if (e <= 0) return {s, 31'd0, 5'b01100};
    return {s, e[7:0], q[22:0], 5'b00000};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int sel;
    sel = int'($urandom_range(0, 19));
    f = 23'($urandom);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else if (sel < 5)  e = 8'($urandom_range(1, 254));
    else               e = 8'($urandom_range(90, 165));
    if ($urandom_range(0, 7) == 0) f = sel[0] ? 23'h7FFFFF : 23'($urandom_range(0, 3));
    return {1'($urandom), e, f};
  endfunction

  // Scoreboard: every transfer must match the oldest expected result; stalled outputs must hold.
  task automatic monitor();
    logic [36:0] held = '0;
    logic [36:0] got;
    logic        held_v = 1'b0;
    forever begin
      @(negedge clk);
      got = {fp_Z, ovrf, udrf, zer, inf, nan};
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          if (held_v) check("stall_hold", {27'd0, got}, {27'd0, held});
          held = got;
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %h, expected no output", got);
          end else begin
            check($sformatf("result#%0d", delivered), {27'd0, got}, {27'd0, exp_q.pop_front()});
          end
          delivered++;
        end
      end
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the operands were accepted.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm, input logic [36:0] e);
    int waited = 0;
    in_valid = 1'b1;
    fp_X = x;
    fp_Y = y;
    r_mode = rm;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs [23];
  logic [31:0] bp_x [4];
  logic [31:0] bp_y [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int d0;
    logic [36:0] z0;
    logic [31:0] rx, ry;
    logic [2:0]  rrm;

    vecs[0]  = '{32'h40400000, 32'h40400000, 3'd1, 32'h41100000, 5'b00000};
    vecs[1]  = '{32'h00490fdb, 32'h40490fdb, 3'd0, 32'h00000000, 5'b00100};
    vecs[2]  = '{32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 5'b00100};
    vecs[3]  = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b00001};
    vecs[4]  = '{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00001};
    vecs[5]  = '{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b10010};
    vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b10000};
    vecs[7]  = '{32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 5'b01100};
    vecs[8]  = '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00000};
    vecs[9]  = '{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00000};
    vecs[10] = '{32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 5'b00000};
    vecs[11] = '{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'b10010};
    vecs[12] = '{32'h7F7FFFFF, 32'h40000000, 3'd2, 32'h7F7FFFFF, 5'b10000};
    vecs[13] = '{32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b10000};
    vecs[14] = '{32'h7F7FFFFF, 32'h40000000, 3'd3, 32'h7F800000, 5'b10010};
    vecs[15] = '{32'hFF800000, 32'h3F800000, 3'd0, 32'hFF800000, 5'b00010};
    vecs[16] = '{32'hFF800000, 32'h80800000, 3'd0, 32'h7F800000, 5'b00010};
    vecs[17] = '{32'h3F800001, 32'h3F800001, 3'd7, 32'h3F800002, 5'b00000};
    vecs[18] = '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 5'b00000};
    vecs[19] = '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 5'b00000};
    vecs[20] = '{32'hBF800003, 32'h3FC00000, 3'd2, 32'hBFC00005, 5'b00000};
    vecs[21] = '{32'h3F800001, 32'h3FFFFFFE, 3'd0, 32'h40000000, 5'b00000};
    vecs[22] = '{32'h3F800001, 32'h3FFFFFFE, 3'd1, 32'h3FFFFFFF, 5'b00000};

    fork
      monitor();
      ready_gen();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({fp_Z, ovrf, udrf, zer, inf, nan}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready_early", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 23; i++) begin
      send(vecs[i].x, vecs[i].y, vecs[i].rm, {vecs[i].z, vecs[i].f});
      drain();
    end

    // Latency: accepted op appears exactly 3 cycles later
    exp_q.push_back({32'h41100000, 5'b00000});
    in_valid = 1'b1;
    fp_X = 32'h40400000;
    fp_Y = 32'h40400000;
    r_mode = 3'd1;
    @(negedge clk);
    check("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", 64'(cnt), 64'd3);
    drain();

    // Backpressure: 4 back-to-back ops with output stalled
    bp_x[0] = 32'h40400000; bp_y[0] = 32'h40400000;
    bp_x[1] = 32'h3F800001; bp_y[1] = 32'h3F800001;
    bp_x[2] = 32'hC0000000; bp_y[2] = 32'h40A00000;
    bp_x[3] = 32'h3FC00000; bp_y[3] = 32'hBFC00000;
    d0 = delivered;
    ready_force = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp_x[i], bp_y[i], 3'd0, ref_mul(bp_x[i], bp_y[i], 3'd0));
      end
      begin
        int w = 0;
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        z0 = {fp_Z, ovrf, udrf, zer, inf, nan};
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_out_valid", 64'(out_valid), 64'd1);
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
          check("bp_hold", 64'({fp_Z, ovrf, udrf, zer, inf, nan}), 64'(z0));
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
      end
    join
    drain();
    check("bp_delivered", 64'(delivered - d0), 64'd4);

    // Reset mid-stream: in-flight ops are discarded
    send(32'h40400000, 32'h40000000, 3'd0, {32'h40C00000, 5'b00000});
    send(32'h40800000, 32'h40000000, 3'd0, {32'h41000000, 5'b00000});
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(32'h40400000, 32'h40400000, 3'd1, {32'h41100000, 5'b00000});
    drain();

    // Randomized traffic with random output backpressure
    ready_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rx = rand_op();
      ry = rand_op();
      rrm = 3'($urandom_range(0, 7));
      send(rx, ry, rrm, ref_mul(rx, ry, rrm));
    end
    ready_rand = 1'b0;
    ready_force = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
